burst_mem_responder: RTL and testbench

- Memory-side responder for the 4-beat x 64-bit burst protocol that the cacheline adaptor drives.
- Holds a line-organised backing store. Accepts one read or write request at a time, waits a programmable latency, then streams or absorbs four 64-bit beats with resp_o high on each beat.
- Used as the memory model under the adaptor/cache in simulation. Synthesisable for small DEPTH.

---
 rtl/burst_mem_if.sv | 20 ++
 rtl/burst_mem_responder.sv | 122 ++++++++++++
 tb/tb_burst_mem_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/burst_mem_if.sv
// Request/beat bus between a burst requester (master) and burst_mem_responder (slave).
interface burst_mem_if;
    logic [31:0] address_i;
    logic        read_i;
    logic        write_i;
    logic [63:0] burst_i;
    logic [63:0] burst_o;
    logic        resp_o;
    logic        err_o;

    modport master (
        output address_i, read_i, write_i, burst_i,
        input  burst_o, resp_o, err_o
    );

    modport slave (
        input  address_i, read_i, write_i, burst_i,
        output burst_o, resp_o, err_o
    );
endinterface

// File: rtl/burst_mem_responder.sv
// Line-organised 4x64-bit burst memory model with programmable first-beat latency.
// Optional critical-word-first beat ordering is enabled with `define BURST_MEM_CWF_EN.
module burst_mem_responder #(
    parameter int IDX_W   = 4,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    burst_mem_if.slave  bus
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       lat_q;
    logic [1:0]             beat_q;
    logic [1:0]             word_q;
    logic                   op_wr_q;
    logic [IDX_W-1:0]       idx_q;
    logic [63:0]            burst_q;
    logic                   resp_q;
    logic                   err_q;

    // Backing store is deliberately not reset: it models DRAM contents.
    logic [3:0][63:0]       mem_q [DEPTH];

    logic [IDX_W-1:0]       req_idx_d;
    logic [1:0]             start_d;
    logic [1:0]             word_nxt_d;
    logic                   req_one_d;
    logic                   req_both_d;

    assign req_idx_d  = bus.address_i[5 +: IDX_W];
    assign word_nxt_d = word_q + 2'd1;
    assign req_one_d  = bus.read_i ^ bus.write_i;
    assign req_both_d = bus.read_i & bus.write_i;

`ifdef BURST_MEM_CWF_EN
    assign start_d = bus.address_i[4:3];

    logic unused_addr;
    assign unused_addr = ^{bus.address_i[31:5+IDX_W], bus.address_i[2:0]};
`else
    assign start_d = 2'd0;

    logic unused_addr;
    assign unused_addr = ^{bus.address_i[31:5+IDX_W], bus.address_i[4:0]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            word_q  <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            burst_q <= '0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_one_d) begin
                        op_wr_q <= bus.write_i;
                        idx_q   <= req_idx_d;
                        word_q  <= start_d;
                        beat_q  <= '0;
                        if (LATENCY == 0) begin
                            state_q <= BURST;
                            resp_q  <= 1'b1;
                            burst_q <= bus.write_i ? '0 : mem_q[req_idx_d][start_d];
                        end else begin
                            state_q <= WAIT;
                            lat_q   <= CNT_W'(LATENCY - 1);
                        end
                    end else if (req_both_d) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (lat_q == '0) begin
                        state_q <= BURST;
                        resp_q  <= 1'b1;
                        burst_q <= op_wr_q ? '0 : mem_q[idx_q][word_q];
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                BURST: begin
                    // Each edge here consumes one beat; the 4th closes the burst.
                    if (beat_q == 2'd3) begin
                        state_q <= DONE;
                        resp_q  <= 1'b0;
                        burst_q <= '0;
                    end else begin
                        beat_q  <= beat_q + 2'd1;
                        word_q  <= word_nxt_d;
                        burst_q <= op_wr_q ? '0 : mem_q[idx_q][word_nxt_d];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write beats commit one at a time, so a reset mid-burst leaves a partial line.
    always_ff @(posedge clk) begin
        if (state_q == BURST && op_wr_q) begin
            mem_q[idx_q][word_q] <= bus.burst_i;
        end
    end

    assign bus.burst_o = burst_q;
    assign bus.resp_o  = resp_q;
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder: table of line transactions plus corner-case sequences.
module tb_burst_mem_responder;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    burst_mem_if bus();

    burst_mem_responder #(.IDX_W(4), .LATENCY(LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit               wr;
        logic [31:0]      addr;
        logic [3:0][63:0] wdata;  // line words W0..W3 to write
        logic [3:0][63:0] exp;    // line words W0..W3 expected on read
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];
    vec_t vecs[9];

    function automatic logic [3:0][63:0] mk(logic [63:0] w0, logic [63:0] w1,
                                            logic [63:0] w2, logic [63:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic int sb(logic [31:0] a);
`ifdef BURST_MEM_CWF_EN
        return int'(a[4:3]);
`else
        return 0;
`endif
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_req(bit wr, logic [31:0] a);
        bus.address_i = a;
        bus.read_i    = !wr;
        bus.write_i   = wr;
    endtask

    task automatic push_read(vec_t v);
        for (int b = 0; b < 4; b++) exp_q.push_back(v.exp[(sb(v.addr) + b) % 4]);
    endtask

    // Waits for the first beat, checks its delay, then handles nb beats.
    task automatic beats(vec_t v, int exp_gap, int nb);
        int gap = 0;
        bit seen = 0;
        while (!seen && gap < 40) begin
            @(negedge clk);
            if (bus.resp_o === 1'b1) seen = 1;
            else gap++;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_timeout: resp_o not seen within 40 cycles");
            return;
        end
        chk("first_beat_gap", 64'(gap), 64'(exp_gap));
        for (int b = 0; b < nb; b++) begin
            if (b > 0) @(negedge clk);
            chk("resp_beat", 64'(bus.resp_o), 64'd1);
            if (v.wr) bus.burst_i = v.wdata[(sb(v.addr) + b) % 4];
            else if (exp_q.size() > 0) chk("read_beat", bus.burst_o, exp_q.pop_front());
            else chk("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
        end
    endtask

    task automatic finish_txn();
        @(negedge clk);
        chk("resp_low_after", 64'(bus.resp_o), 64'd0);
        chk("burst_zero_after", bus.burst_o, 64'd0);
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        bus.burst_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vecs[0] = '{wr: 1'b1, addr: 32'h40,
                    wdata: mk(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444), exp: '0};
        vecs[1] = '{wr: 1'b0, addr: 32'h40, wdata: '0,
                    exp: mk(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444)};
        vecs[2] = '{wr: 1'b1, addr: 32'h80,
                    wdata: mk(64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                              64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888), exp: '0};
        vecs[3] = '{wr: 1'b1, addr: 32'h2D8,
                    wdata: mk(64'h9999_9999_9999_9999, 64'hA5A5_A5A5_A5A5_A5A5,
                              64'h5A5A_5A5A_5A5A_5A5A, 64'hDEAD_BEEF_CAFE_F00D), exp: '0};
        vecs[4] = '{wr: 1'b0, addr: 32'hC0, wdata: '0,
                    exp: mk(64'h9999_9999_9999_9999, 64'hA5A5_A5A5_A5A5_A5A5,
                            64'h5A5A_5A5A_5A5A_5A5A, 64'hDEAD_BEEF_CAFE_F00D)};
        vecs[5] = '{wr: 1'b0, addr: 32'h80, wdata: '0,
                    exp: mk(64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                            64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888)};
        vecs[6] = '{wr: 1'b0, addr: 32'h50, wdata: '0,
                    exp: mk(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444)};
        vecs[7] = '{wr: 1'b1, addr: 32'h58,
                    wdata: mk(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                              64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0), exp: '0};
        vecs[8] = '{wr: 1'b0, addr: 32'h40, wdata: '0,
                    exp: mk(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                            64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0)};

        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        repeat (3) @(negedge clk);
        chk("reset_resp", 64'(bus.resp_o), 64'd0);
        chk("reset_burst", bus.burst_o, 64'd0);
        chk("reset_err", 64'(bus.err_o), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start_req(vecs[i].wr, vecs[i].addr);
            if (!vecs[i].wr) push_read(vecs[i]);
            beats(vecs[i], LAT, 4);
            finish_txn();
        end

        // Held read: second burst follows after DONE, the IDLE accept cycle and LATENCY.
        @(negedge clk);
        start_req(1'b0, 32'h40);
        push_read(vecs[8]);
        push_read(vecs[8]);
        beats(vecs[8], LAT, 4);
        beats(vecs[8], LAT + 2, 4);
        finish_txn();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("err_clean", 64'(bus.err_o), 64'd0);

        @(negedge clk);
        bus.read_i  = 1'b1;
        bus.write_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("proto_no_resp", 64'(bus.resp_o), 64'd0);
        end
        chk("proto_err_set", 64'(bus.err_o), 64'd1);
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("proto_err_sticky", 64'(bus.err_o), 64'd1);

        // Reset during a write after two committed beats.
        v = '{wr: 1'b1, addr: 32'h80,
              wdata: mk(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                        64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD), exp: '0};
        @(negedge clk);
        start_req(1'b1, 32'h80);
        beats(v, LAT, 2);
        @(negedge clk);
        chk("mid_burst_resp", 64'(bus.resp_o), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_resp", 64'(bus.resp_o), 64'd0);
        chk("async_reset_burst", bus.burst_o, 64'd0);
        chk("async_reset_err", 64'(bus.err_o), 64'd0);
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        bus.burst_i = '0;
        @(negedge clk);
        reset_n = 1'b1;

        v = '{wr: 1'b0, addr: 32'h80, wdata: '0,
              exp: mk(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                      64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888)};
        @(negedge clk);
        start_req(1'b0, v.addr);
        push_read(v);
        beats(v, LAT, 4);
        finish_txn();
        chk("scoreboard_final_empty", 64'(exp_q.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
